// File: rtl/pipeline_types.sv
// Shared decode/dispatch types: functional-unit selector and decoded control payload.
package pipeline_types;

   typedef enum logic [1:0] {
      FU_ALU    = 2'd0,
      FU_LSU    = 2'd1,
      FU_BRANCH = 2'd2
   } fu_type_t;

   typedef struct packed {
      logic [3:0]  alu_op;
      logic [31:0] imm;
      logic        mem_rd;
      logic        mem_wr;
      logic        is_jump;
   } ctrl_payload_t;

endpackage

// File: rtl/dispatch_ctrl.sv
// Dispatch controller: one-entry decode->issue slot gated by per-FU RS credits, ROB space and free list.
// Optional DISPATCH_STALL_CNT_EN adds a 32-bit stall cycle counter on stall_cnt_o.
module dispatch_ctrl
   import pipeline_types::*;
#(
   parameter int ALU_RS_DEPTH = 8,
   parameter int LSU_RS_DEPTH = 8,
   parameter int BR_RS_DEPTH  = 4,
   localparam int AW = $clog2(ALU_RS_DEPTH+1),
   localparam int LW = $clog2(LSU_RS_DEPTH+1),
   localparam int BW = $clog2(BR_RS_DEPTH+1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush_i,
   input  logic          dec_valid_i,
   output logic          dec_ready_o,
   input  fu_type_t      dec_fu_type_i,
   input  logic          dec_rd_used_i,
   input  logic [16:0]   dec_regs_i,
   input  ctrl_payload_t dec_payload_i,
   input  logic          rob_full_i,
   input  logic          freelist_empty_i,
   input  logic          alu_free_i,
   input  logic          lsu_free_i,
   input  logic          br_free_i,
   output logic          disp_valid_o,
   output fu_type_t      disp_fu_type_o,
   output logic          disp_rd_used_o,
   output logic [16:0]   disp_regs_o,
   output ctrl_payload_t disp_payload_o,
`ifdef DISPATCH_STALL_CNT_EN
   output logic [31:0]   stall_cnt_o,
`endif
   output logic [AW-1:0] alu_credit_o,
   output logic [LW-1:0] lsu_credit_o,
   output logic [BW-1:0] br_credit_o
);

   logic          hold_q, hold_d;
   fu_type_t      fu_q;
   logic          rd_used_q;
   logic [16:0]   regs_q;
   ctrl_payload_t payload_q;
   logic [AW-1:0] alu_cred_q, alu_cred_d;
   logic [LW-1:0] lsu_cred_q, lsu_cred_d;
   logic [BW-1:0] br_cred_q, br_cred_d;

   logic is_lsu, is_br, is_alu, need_preg, credit_ok, fire, load;
   logic alu_take, lsu_take, br_take;

   // Any encoding other than LSU/BRANCH is accounted against the ALU RS.
   assign is_lsu    = (fu_q == FU_LSU);
   assign is_br     = (fu_q == FU_BRANCH);
   assign is_alu    = !is_lsu && !is_br;
   assign need_preg = rd_used_q && (regs_q[4:0] != 5'd0);
   assign credit_ok = is_lsu ? (lsu_cred_q != '0) :
                      is_br  ? (br_cred_q  != '0) : (alu_cred_q != '0);

   assign fire         = hold_q && !flush_i && credit_ok && !rob_full_i &&
                         !(need_preg && freelist_empty_i);
   assign dec_ready_o  = !flush_i && (!hold_q || fire);
   assign load         = dec_valid_i && dec_ready_o;
   assign disp_valid_o = fire;

   assign alu_take = fire && is_alu;
   assign lsu_take = fire && is_lsu;
   assign br_take  = fire && is_br;

   always_comb begin
      hold_d = hold_q;
      if (flush_i)   hold_d = 1'b0;
      else if (load) hold_d = 1'b1;
      else if (fire) hold_d = 1'b0;
   end

   // Take and free in the same cycle cancel; a stray free at full credit saturates.
   always_comb begin
      alu_cred_d = alu_cred_q;
      if (flush_i)                     alu_cred_d = AW'(ALU_RS_DEPTH);
      else if (alu_take && !alu_free_i) alu_cred_d = alu_cred_q - 1'b1;
      else if (!alu_take && alu_free_i && alu_cred_q != AW'(ALU_RS_DEPTH))
                                       alu_cred_d = alu_cred_q + 1'b1;
   end

   always_comb begin
      lsu_cred_d = lsu_cred_q;
      if (flush_i)                     lsu_cred_d = LW'(LSU_RS_DEPTH);
      else if (lsu_take && !lsu_free_i) lsu_cred_d = lsu_cred_q - 1'b1;
      else if (!lsu_take && lsu_free_i && lsu_cred_q != LW'(LSU_RS_DEPTH))
                                       lsu_cred_d = lsu_cred_q + 1'b1;
   end

   always_comb begin
      br_cred_d = br_cred_q;
      if (flush_i)                   br_cred_d = BW'(BR_RS_DEPTH);
      else if (br_take && !br_free_i) br_cred_d = br_cred_q - 1'b1;
      else if (!br_take && br_free_i && br_cred_q != BW'(BR_RS_DEPTH))
                                     br_cred_d = br_cred_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q     <= 1'b0;
         fu_q       <= FU_ALU;
         rd_used_q  <= 1'b0;
         regs_q     <= '0;
         payload_q  <= '0;
         alu_cred_q <= AW'(ALU_RS_DEPTH);
         lsu_cred_q <= LW'(LSU_RS_DEPTH);
         br_cred_q  <= BW'(BR_RS_DEPTH);
      end else begin
         hold_q     <= hold_d;
         alu_cred_q <= alu_cred_d;
         lsu_cred_q <= lsu_cred_d;
         br_cred_q  <= br_cred_d;
         if (load) begin
            fu_q      <= dec_fu_type_i;
            rd_used_q <= dec_rd_used_i;
            regs_q    <= dec_regs_i;
            payload_q <= dec_payload_i;
         end
      end
   end

   always @(posedge clk) begin
      if (rst_n && !flush_i) begin
         assert (!(alu_free_i && !alu_take && alu_cred_q == AW'(ALU_RS_DEPTH)));
         assert (!(lsu_free_i && !lsu_take && lsu_cred_q == LW'(LSU_RS_DEPTH)));
         assert (!(br_free_i  && !br_take  && br_cred_q  == BW'(BR_RS_DEPTH)));
      end
   end

`ifdef DISPATCH_STALL_CNT_EN
   logic [31:0] stall_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          stall_q <= '0;
      else if (hold_q && !fire && !flush_i) stall_q <= stall_q + 32'd1;
   end
   assign stall_cnt_o = stall_q;
`endif

   assign disp_fu_type_o = fu_q;
   assign disp_rd_used_o = rd_used_q;
   assign disp_regs_o    = regs_q;
   assign disp_payload_o = payload_q;
   assign alu_credit_o   = alu_cred_q;
   assign lsu_credit_o   = lsu_cred_q;
   assign br_credit_o    = br_cred_q;

endmodule
